// File: rtl/wb_stage_reg.sv
// ---------------------------------------------------------------------------
// wb_stage_reg
//
// Write-back pipeline stage register with a single skid entry. Entries
// arriving from the MEM stage are held in a head register. If downstream
// stalls while a new entry arrives, that entry goes into the skid register.
// The head drives the register-file / WWD write-back path.
//
// Ports
//   clk            clock, rising edge
//   reset_n        asynchronous active-low reset
//   in_valid       upstream entry present
//   in_ready       stage can accept this cycle (from state only)
//   in_memdata     memory read data
//   in_alu         ALU result
//   in_rd          destination register index
//   in_memtoreg    select memdata (1) or ALU result (0) for write-back
//   in_regwrite    entry writes the register file
//   in_wwd         entry is a WWD operation
//   flush          synchronous discard of all held entries
//   out_valid      head entry present
//   out_ready      downstream consumes head this cycle
//   out_wbdata     selected write-back value of head
//   out_rd         destination register of head
//   out_regwrite   head control bits, forced 0 when no head
//   out_memtoreg
//   out_wwd
//   is_wb          sticky: an entry has been accepted since reset
//   retire_count   number of entries consumed downstream (wraps)
//
// state   | meaning
// --------+------------------------------------------
// S_EMPTY | no entry held
// S_ONE   | head valid, skid empty
// S_FULL  | head and skid valid, input blocked
// ---------------------------------------------------------------------------
module wb_stage_reg #(
   parameter int WORD_SIZE = 16,
   parameter int RD_W      = 2,
   parameter int WARMUP    = 3,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_SIZE-1:0] in_memdata,
   input  logic [WORD_SIZE-1:0] in_alu,
   input  logic [RD_W-1:0]      in_rd,
   input  logic                 in_memtoreg,
   input  logic                 in_regwrite,
   input  logic                 in_wwd,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_wbdata,
   output logic [RD_W-1:0]      out_rd,
   output logic                 out_regwrite,
   output logic                 out_memtoreg,
   output logic                 out_wwd,
   output logic                 is_wb,
   output logic [CNT_W-1:0]     retire_count
);

   localparam int WU_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
   localparam logic [WU_W-1:0] WU_MAX = WU_W'(WARMUP);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t state, next_state;

   logic [WU_W-1:0] wu_cnt;
   logic            warm;

   logic [WORD_SIZE-1:0] head_memdata, head_alu, skid_memdata, skid_alu;
   logic [RD_W-1:0]      head_rd, skid_rd;
   logic                 head_memtoreg, head_regwrite, head_wwd;
   logic                 skid_memtoreg, skid_regwrite, skid_wwd;

   logic accept, pop;
   logic load_head_in, load_skid_in, move_skid;

   // Warm-up: count edges out of reset, saturating at WARMUP.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wu_cnt <= '0;
      end else if (wu_cnt != WU_MAX) begin
         wu_cnt <= wu_cnt + WU_W'(1);
      end
   end

   assign warm      = (wu_cnt == WU_MAX);
   assign in_ready  = warm && (state != S_FULL);
   assign out_valid = (state != S_EMPTY);
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_EMPTY;
      end else begin
         state <= next_state;
      end
   end

   // Flush wins over accept and pop; storage is left untouched so the
   // data/rd outputs keep showing the last head value.
   always_comb begin
      next_state   = state;
      load_head_in = 1'b0;
      load_skid_in = 1'b0;
      move_skid    = 1'b0;
      if (flush) begin
         next_state = S_EMPTY;
      end else begin
         unique case (state)
            S_EMPTY: begin
               if (accept) begin
                  next_state   = S_ONE;
                  load_head_in = 1'b1;
               end
            end
            S_ONE: begin
               if (accept && pop) begin
                  load_head_in = 1'b1;
               end else if (accept) begin
                  next_state   = S_FULL;
                  load_skid_in = 1'b1;
               end else if (pop) begin
                  next_state = S_EMPTY;
               end
            end
            S_FULL: begin
               if (pop) begin
                  next_state = S_ONE;
                  move_skid  = 1'b1;
               end
            end
            default: next_state = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_memdata  <= '0;
         head_alu      <= '0;
         head_rd       <= '0;
         head_memtoreg <= 1'b0;
         head_regwrite <= 1'b0;
         head_wwd      <= 1'b0;
      end else if (load_head_in) begin
         head_memdata  <= in_memdata;
         head_alu      <= in_alu;
         head_rd       <= in_rd;
         head_memtoreg <= in_memtoreg;
         head_regwrite <= in_regwrite;
         head_wwd      <= in_wwd;
      end else if (move_skid) begin
         head_memdata  <= skid_memdata;
         head_alu      <= skid_alu;
         head_rd       <= skid_rd;
         head_memtoreg <= skid_memtoreg;
         head_regwrite <= skid_regwrite;
         head_wwd      <= skid_wwd;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         skid_memdata  <= '0;
         skid_alu      <= '0;
         skid_rd       <= '0;
         skid_memtoreg <= 1'b0;
         skid_regwrite <= 1'b0;
         skid_wwd      <= 1'b0;
      end else if (load_skid_in) begin
         skid_memdata  <= in_memdata;
         skid_alu      <= in_alu;
         skid_rd       <= in_rd;
         skid_memtoreg <= in_memtoreg;
         skid_regwrite <= in_regwrite;
         skid_wwd      <= in_wwd;
      end else if (move_skid) begin
         skid_memdata  <= '0;
         skid_alu      <= '0;
         skid_rd       <= '0;
         skid_memtoreg <= 1'b0;
         skid_regwrite <= 1'b0;
         skid_wwd      <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         is_wb        <= 1'b0;
         retire_count <= '0;
      end else if (!flush) begin
         if (accept) begin
            is_wb <= 1'b1;
         end
         if (pop) begin
            retire_count <= retire_count + CNT_W'(1);
         end
      end
   end

   // Data and rd follow the head even when empty; control bits are gated
   // so an empty stage can never cause a register-file write.
   assign out_wbdata   = head_memtoreg ? head_memdata : head_alu;
   assign out_rd       = head_rd;
   assign out_regwrite = out_valid && head_regwrite;
   assign out_memtoreg = out_valid && head_memtoreg;
   assign out_wwd      = out_valid && head_wwd;

endmodule

// File: tb/tb_wb_stage_reg.sv
module tb_wb_stage_reg;

   localparam int WARMUP = 3;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_memtoreg, in_regwrite, in_wwd, flush, out_ready;
   logic [15:0] in_memdata, in_alu;
   logic [1:0]  in_rd;

   logic        in_ready, out_valid, out_regwrite, out_memtoreg, out_wwd, is_wb;
   logic [15:0] out_wbdata, retire_count;
   logic [1:0]  out_rd;

   logic        c_in_ready, c_out_valid, c_out_regwrite, c_out_memtoreg, c_out_wwd, c_is_wb;
   logic [15:0] c_out_wbdata;
   logic [1:0]  c_out_rd;
   logic [3:0]  c_retire_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_stage_reg #(.WORD_SIZE(16), .RD_W(2), .WARMUP(WARMUP), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_memdata(in_memdata), .in_alu(in_alu), .in_rd(in_rd),
      .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .in_wwd(in_wwd),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_wbdata(out_wbdata), .out_rd(out_rd), .out_regwrite(out_regwrite),
      .out_memtoreg(out_memtoreg), .out_wwd(out_wwd), .is_wb(is_wb),
      .retire_count(retire_count));

   wb_stage_reg #(.WORD_SIZE(16), .RD_W(2), .WARMUP(WARMUP), .CNT_W(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_memdata(in_memdata), .in_alu(in_alu), .in_rd(in_rd),
      .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .in_wwd(in_wwd),
      .flush(flush), .out_valid(c_out_valid), .out_ready(out_ready),
      .out_wbdata(c_out_wbdata), .out_rd(c_out_rd), .out_regwrite(c_out_regwrite),
      .out_memtoreg(c_out_memtoreg), .out_wwd(c_out_wwd), .is_wb(c_is_wb),
      .retire_count(c_retire_count));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of at most two entries.
   typedef struct {
      logic [15:0] md;
      logic [15:0] alu;
      logic [1:0]  rd;
      logic        m2r;
      logic        rw;
      logic        wwd;
   } ent_t;

   ent_t        q[$];
   ent_t        m_e;
   int          m_wu;
   bit          m_is_wb;
   int unsigned m_cnt;
   logic [15:0] m_last_wb;
   logic [1:0]  m_last_rd;
   bit          m_rdy, m_acc, m_pop;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
         m_wu      = 0;
         m_is_wb   = 0;
         m_cnt     = 0;
         m_last_wb = '0;
         m_last_rd = '0;
      end else begin
         m_rdy = (m_wu == WARMUP) && (q.size() < 2);
         m_acc = in_valid && m_rdy;
         m_pop = (q.size() > 0) && out_ready;
         m_e.md = in_memdata; m_e.alu = in_alu; m_e.rd = in_rd;
         m_e.m2r = in_memtoreg; m_e.rw = in_regwrite; m_e.wwd = in_wwd;
         if (flush) begin
            q.delete();
         end else begin
            if (m_pop) begin
               void'(q.pop_front());
               m_cnt++;
            end
            if (m_acc) begin
               q.push_back(m_e);
               m_is_wb = 1;
            end
         end
         if (m_wu < WARMUP) m_wu++;
         if (q.size() > 0) begin
            m_last_wb = q[0].m2r ? q[0].md : q[0].alu;
            m_last_rd = q[0].rd;
         end
      end
   end

   // Compare process: every falling edge, both instances against the model.
   always @(negedge clk) begin
      logic        e_rdy, e_vld, e_rw, e_m2r, e_wwd;
      logic [15:0] e_cnt;
      logic [3:0]  e_cnt4;
      e_rdy  = (m_wu == WARMUP) && (q.size() < 2);
      e_vld  = q.size() > 0;
      e_rw   = e_vld ? q[0].rw  : 1'b0;
      e_m2r  = e_vld ? q[0].m2r : 1'b0;
      e_wwd  = e_vld ? q[0].wwd : 1'b0;
      e_cnt  = m_cnt[15:0];
      e_cnt4 = m_cnt[3:0];
      chk("in_ready",      32'(in_ready),       32'(e_rdy));
      chk("out_valid",     32'(out_valid),      32'(e_vld));
      chk("out_wbdata",    32'(out_wbdata),     32'(m_last_wb));
      chk("out_rd",        32'(out_rd),         32'(m_last_rd));
      chk("out_regwrite",  32'(out_regwrite),   32'(e_rw));
      chk("out_memtoreg",  32'(out_memtoreg),   32'(e_m2r));
      chk("out_wwd",       32'(out_wwd),        32'(e_wwd));
      chk("is_wb",         32'(is_wb),          32'(m_is_wb));
      chk("retire_count",  32'(retire_count),   32'(e_cnt));
      chk("c4_in_ready",   32'(c_in_ready),     32'(e_rdy));
      chk("c4_out_valid",  32'(c_out_valid),    32'(e_vld));
      chk("c4_out_wbdata", 32'(c_out_wbdata),   32'(m_last_wb));
      chk("c4_out_rd",     32'(c_out_rd),       32'(m_last_rd));
      chk("c4_ctrl",       32'({c_out_regwrite, c_out_memtoreg, c_out_wwd}), 32'({e_rw, e_m2r, e_wwd}));
      chk("c4_is_wb",      32'(c_is_wb),        32'(m_is_wb));
      chk("c4_retire",     32'(c_retire_count), 32'(e_cnt4));
   end

   task automatic drive(input logic v, input logic rdy, input logic fl,
                        input logic [15:0] md, input logic [15:0] alu, input logic [1:0] rd,
                        input logic m2r, input logic rw, input logic wwd);
      in_valid = v; out_ready = rdy; flush = fl;
      in_memdata = md; in_alu = alu; in_rd = rd;
      in_memtoreg = m2r; in_regwrite = rw; in_wwd = wwd;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      drive(0, 0, 0, 16'h0, 16'h0, 2'd0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_is_wb",     32'(is_wb),     32'd0);
      chk("rst_retire",    32'(retire_count), 32'd0);

      // Warm-up with in_valid held high; first accept on edge 4.
      reset_n = 1'b1;
      drive(1, 0, 0, 16'hBEEF, 16'h0001, 2'd2, 1, 1, 0);
      chk("wu_ready_e0", 32'(in_ready), 32'd0);
      step();
      chk("wu_ready_e1", 32'(in_ready), 32'd0);
      step();
      chk("wu_ready_e2", 32'(in_ready), 32'd0);
      chk("wu_valid_e2", 32'(out_valid), 32'd0);
      step();
      chk("wu_ready_e3", 32'(in_ready), 32'd1);
      chk("wu_is_wb_e3", 32'(is_wb), 32'd0);
      step();
      chk("acc_is_wb",   32'(is_wb), 32'd1);
      chk("acc_valid",   32'(out_valid), 32'd1);
      chk("acc_wbdata",  32'(out_wbdata), 32'hBEEF);
      chk("acc_rd",      32'(out_rd), 32'd2);
      drive(0, 1, 0, 16'h0, 16'h0, 2'd0, 0, 0, 0);
      step();
      chk("pop_retire",  32'(retire_count), 32'd1);
      chk("pop_valid",   32'(out_valid), 32'd0);
      chk("pop_hold_wb", 32'(out_wbdata), 32'hBEEF);

      // Back-pressure: A then B into a stalled stage, then drain.
      drive(1, 0, 0, 16'h5555, 16'h1111, 2'd1, 0, 1, 0);
      step();
      drive(1, 0, 0, 16'h6666, 16'h2222, 2'd3, 0, 1, 1);
      step();
      chk("full_ready",  32'(in_ready), 32'd0);
      chk("full_head",   32'(out_wbdata), 32'h1111);
      chk("full_rd",     32'(out_rd), 32'd1);
      drive(0, 1, 0, 16'h0, 16'h0, 2'd0, 0, 0, 0);
      step();
      chk("drain_b",     32'(out_wbdata), 32'h2222);
      chk("drain_b_wwd", 32'(out_wwd), 32'd1);
      step();
      chk("drain_empty", 32'(out_valid), 32'd0);
      chk("drain_cnt",   32'(retire_count), 32'd3);

      // Flush from FULL with a competing input.
      drive(1, 0, 0, 16'h5555, 16'h1111, 2'd1, 0, 1, 0);
      step();
      drive(1, 0, 0, 16'h6666, 16'h2222, 2'd3, 0, 1, 0);
      step();
      drive(1, 1, 1, 16'h7777, 16'h3333, 2'd2, 0, 1, 0);
      step();
      chk("fl_valid",    32'(out_valid), 32'd0);
      chk("fl_regwrite", 32'(out_regwrite), 32'd0);
      chk("fl_cnt",      32'(retire_count), 32'd3);
      chk("fl_hold_wb",  32'(out_wbdata), 32'h1111);
      drive(0, 1, 0, 16'h0, 16'h0, 2'd0, 0, 0, 0);
      step();
      chk("fl_dropped",  32'(out_valid), 32'd0);

      // Streaming: 1 fill edge then 13 pops takes the count from 3 to 16.
      for (int i = 0; i < 14; i++) begin
         drive(1, 1, 0, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 1'($urandom));
         step();
      end
      chk("stream_cnt",  32'(retire_count), 32'd16);
      chk("wrap_cnt4",   32'(c_retire_count), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
               1'($urandom_range(0, 29) == 0),
               16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 1'($urandom));
         step();
      end

      // Asynchronous reset while FULL, then warm-up restarts.
      drive(0, 0, 1, 16'h0, 16'h0, 2'd0, 0, 0, 0);
      step();
      drive(1, 0, 0, 16'hAAAA, 16'h1234, 2'd1, 1, 1, 1);
      step();
      drive(1, 0, 0, 16'hBBBB, 16'h4321, 2'd2, 0, 1, 0);
      step();
      chk("pre_rst_full", 32'({out_valid, in_ready}), 32'b10);
      drive(0, 0, 0, 16'h0, 16'h0, 2'd0, 0, 0, 0);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_valid",  32'(out_valid), 32'd0);
      chk("arst_is_wb",  32'(is_wb), 32'd0);
      chk("arst_cnt",    32'(retire_count), 32'd0);
      chk("arst_wbdata", 32'(out_wbdata), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(1, 1, 0, 16'hCAFE, 16'h0F0F, 2'd3, 0, 1, 0);
      chk("rewu_e0", 32'(in_ready), 32'd0);
      step();
      chk("rewu_e1", 32'(in_ready), 32'd0);
      step();
      chk("rewu_e2", 32'(in_ready), 32'd0);
      step();
      chk("rewu_e3", 32'(in_ready), 32'd1);
      step();
      chk("rewu_acc", 32'(out_wbdata), 32'h0F0F);
      drive(0, 1, 0, 16'h0, 16'h0, 2'd0, 0, 0, 0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
